// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera SCCB register loader.
// The DELAY state only exists when CAM_CFG_DELAY_EN is defined.
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_BYTE,
        ST_STOP,
        ST_GAP,
        ST_DONE
`ifdef CAM_CFG_DELAY_EN
        , ST_DELAY
`endif
    } state_e;

    typedef enum logic [1:0] {
        CMD_START,
        CMD_BYTE,
        CMD_STOP,
        CMD_GAP
    } phy_cmd_e;

    typedef struct packed {
        logic [15:0] reg_addr;
        logic [7:0]  data;
    } entry_t;

    localparam logic [15:0] DELAY_ADDR   = 16'hFFFF;
    localparam logic [7:0]  DEF_DEV_ADDR = 8'h78;

endpackage

// File: rtl/sccb_phy.sv
// SCCB bit engine: quarter-bit tick, START, 8 data bits + don't-care 9th bit,
// STOP and idle GAP, one command per cmd/ready handshake.
module sccb_phy
    import cam_cfg_pkg::*;
#(
    parameter int QTR = 125
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    input  phy_cmd_e   cmd_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       scl_o,
    output logic       sda_oe_o
);

    localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

    logic [QW-1:0] tcnt_q;
    logic          active_q;
    phy_cmd_e      cmd_q;
    logic [7:0]    byte_q;
    logic [5:0]    step_q;
    logic          scl_q, oe_q;
    logic          tick;
    logic [5:0]    last_step;

    // Bus levels {scl, sda_oe} for quarter-bit step s of command c.
    function automatic logic [1:0] drive(input phy_cmd_e c, input logic [5:0] s,
                                         input logic [7:0] b);
        logic [1:0] r;
        r = 2'b10;
        case (c)
            CMD_START: r = {1'b1, s[0]};
            CMD_BYTE:  r = {s[1], (s[5:2] < 4'd8) && !b[~s[4:2]]};
            CMD_STOP:  r = {s != 6'd0, s != 6'd2};
            default:   r = 2'b10;
        endcase
        return r;
    endfunction

    assign tick = active_q && (tcnt_q == QW'(QTR - 1));

    always_comb begin
        last_step = 6'd3;
        case (cmd_q)
            CMD_START: last_step = 6'd1;
            CMD_BYTE:  last_step = 6'd35;
            CMD_STOP:  last_step = 6'd2;
            default:   last_step = 6'd3;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            tcnt_q   <= '0;
            step_q   <= '0;
            cmd_q    <= CMD_GAP;
            byte_q   <= '0;
            scl_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else if (!active_q) begin
            if (cmd_valid_i) begin
                active_q       <= 1'b1;
                cmd_q          <= cmd_i;
                byte_q         <= byte_i;
                step_q         <= '0;
                tcnt_q         <= '0;
                {scl_q, oe_q}  <= drive(cmd_i, 6'd0, byte_i);
            end
        end else if (tick) begin
            tcnt_q <= '0;
            if (step_q == last_step) begin
                active_q <= 1'b0;
            end else begin
                step_q        <= step_q + 6'd1;
                {scl_q, oe_q} <= drive(cmd_q, step_q + 6'd1, byte_q);
            end
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign ready_o  = !active_q;
    assign scl_o    = scl_q;
    assign sda_oe_o = oe_q;

endmodule

// File: rtl/cam_cfg.sv
// Camera configuration sequencer: walks a register table and writes each entry
// over SCCB. Define CAM_CFG_DELAY_EN to treat reg_addr 16'hFFFF as a ms delay.
module cam_cfg
    import cam_cfg_pkg::*;
#(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ = 100_000,
    parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  tbl_len_i,
    output logic [7:0]  tbl_addr_o,
    input  logic [23:0] tbl_data_i,
    output logic        scl_o,
    output logic        sda_oe_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int QTR = CLK_FREQ / (4 * SCL_FREQ);
`ifdef CAM_CFG_DELAY_EN
    localparam logic [31:0] MS_CYC = 32'(CLK_FREQ / 1000);
    logic [31:0] dly_q;
`endif

    state_e     state_q;
    logic [7:0] idx_q, len_q;
    entry_t     entry_q, fetched;
    logic [1:0] bcnt_q;
    logic       fph_q, issued_q, busy_q, done_q;
    logic       phy_ready, phy_done, cmd_valid, last_entry;
    phy_cmd_e   cmd;
    logic [7:0] cmd_byte;

    assign fetched    = entry_t'(tbl_data_i);
    assign phy_done   = issued_q && phy_ready;
    assign last_entry = (idx_q == len_q - 8'd1);

    // Each bus state issues exactly one phy command, then waits for it to finish.
    always_comb begin
        cmd       = CMD_GAP;
        cmd_valid = 1'b0;
        case (state_q)
            ST_START: begin cmd = CMD_START; cmd_valid = !issued_q; end
            ST_BYTE:  begin cmd = CMD_BYTE;  cmd_valid = !issued_q; end
            ST_STOP:  begin cmd = CMD_STOP;  cmd_valid = !issued_q; end
            ST_GAP:   begin cmd = CMD_GAP;   cmd_valid = !issued_q; end
            default:  ;
        endcase
        case (bcnt_q)
            2'd0:    cmd_byte = DEV_ADDR;
            2'd1:    cmd_byte = entry_q.reg_addr[15:8];
            2'd2:    cmd_byte = entry_q.reg_addr[7:0];
            default: cmd_byte = entry_q.data;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            entry_q  <= '0;
            bcnt_q   <= '0;
            fph_q    <= 1'b0;
            issued_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CAM_CFG_DELAY_EN
            dly_q    <= '0;
`endif
        end else begin
            if (cmd_valid && phy_ready) issued_q <= 1'b1;
            else if (phy_done)          issued_q <= 1'b0;

            case (state_q)
                ST_IDLE: if (start_i) begin
                    idx_q   <= '0;
                    len_q   <= tbl_len_i;
                    done_q  <= (tbl_len_i == 8'd0);
                    busy_q  <= (tbl_len_i != 8'd0);
                    state_q <= (tbl_len_i == 8'd0) ? ST_DONE : ST_FETCH;
                end
                // Address is driven on entry; data arrives on the second cycle.
                ST_FETCH: if (!fph_q) begin
                    fph_q <= 1'b1;
                end else begin
                    fph_q   <= 1'b0;
                    entry_q <= fetched;
`ifdef CAM_CFG_DELAY_EN
                    if (fetched.reg_addr == DELAY_ADDR) begin
                        if (fetched.data == 8'd0) begin
                            if (last_entry) begin
                                state_q <= ST_DONE; done_q <= 1'b1; busy_q <= 1'b0;
                            end else begin
                                idx_q <= idx_q + 8'd1; state_q <= ST_FETCH;
                            end
                        end else begin
                            dly_q   <= 32'(fetched.data) * MS_CYC;
                            state_q <= ST_DELAY;
                        end
                    end else
`endif
                    state_q <= ST_START;
                end
                ST_START: if (phy_done) begin
                    bcnt_q  <= 2'd0;
                    state_q <= ST_BYTE;
                end
                ST_BYTE: if (phy_done) begin
                    if (bcnt_q == 2'd3) state_q <= ST_STOP;
                    else                bcnt_q  <= bcnt_q + 2'd1;
                end
                ST_STOP: if (phy_done) state_q <= ST_GAP;
                ST_GAP: if (phy_done) begin
                    if (last_entry) begin
                        state_q <= ST_DONE; done_q <= 1'b1; busy_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 8'd1; state_q <= ST_FETCH;
                    end
                end
`ifdef CAM_CFG_DELAY_EN
                ST_DELAY: if (dly_q <= 32'd1) begin
                    if (last_entry) begin
                        state_q <= ST_DONE; done_q <= 1'b1; busy_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 8'd1; state_q <= ST_FETCH;
                    end
                end else begin
                    dly_q <= dly_q - 32'd1;
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sccb_phy #(.QTR(QTR)) u_phy (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cmd_valid_i (cmd_valid),
        .cmd_i       (cmd),
        .byte_i      (cmd_byte),
        .ready_o     (phy_ready),
        .scl_o       (scl_o),
        .sda_oe_o    (sda_oe_o)
    );

    assign tbl_addr_o = idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_cam_cfg.sv
// Directed bench for cam_cfg: decodes the SCCB bus and checks bytes, framing,
// table walk, timing, start filtering, async reset and the delay entry.
module tb_cam_cfg;
    localparam int CF = 800_000;
    localparam int SF = 100_000;   // QTR = 2 cycles, 1 ms = 800 cycles

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [7:0]  taddr;
    logic [23:0] tdata = 24'd0;
    logic        scl, sda_oe, busy, done;
    logic [23:0] tbl [256];

    always #5 clk = ~clk;
    always @(posedge clk) tdata <= tbl[taddr];

    cam_cfg #(.CLK_FREQ(CF), .SCL_FREQ(SF), .DEV_ADDR(8'h78)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .tbl_len_i(len),
        .tbl_addr_o(taddr), .tbl_data_i(tdata), .scl_o(scl), .sda_oe_o(sda_oe),
        .busy_o(busy), .done_o(done));

    // ---- bus monitor ----
    wire  sda_line = ~sda_oe;
    int   cyc_now = 0;
    logic pscl = 1'b1, psda = 1'b1;
    int   nstart = 0, nstop = 0, nchg = 0, bitn = 0, gap_bad = 0, last_gap = 0;
    int   stop_t = -100000;
    logic [7:0] sh = 8'd0;
    logic [7:0] bq[$];
    int   alog[$];

    always @(posedge clk) cyc_now <= cyc_now + 1;

    always @(negedge clk) begin
        if (scl != pscl || sda_line != psda) nchg <= nchg + 1;
        if (scl && pscl && psda && !sda_line) begin
            nstart   <= nstart + 1;
            bitn     <= 0;
            alog.push_back(int'(taddr));
            last_gap <= cyc_now - stop_t;
            if (cyc_now - stop_t < 8) gap_bad <= gap_bad + 1;
        end else if (scl && pscl && !psda && sda_line) begin
            nstop  <= nstop + 1;
            stop_t <= cyc_now;
        end else if (scl && !pscl) begin
            if (bitn < 8) sh <= {sh[6:0], sda_line};
            if (bitn == 8) begin
                bq.push_back(sh);
                bitn <= 0;
            end else begin
                bitn <= bitn + 1;
            end
        end
        pscl <= scl;
        psda <= sda_line;
    end

    // ---- checking ----
    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        if (i < bq.size()) return bq[i];
        return 8'hxx;
    endfunction

    // Pulse start, wait for done; cyc = cycles from the accepting edge.
    task automatic run(input logic [7:0] n, input int mid_start, output int cyc,
                       output logic busy1);
        @(posedge clk); #1 len = n; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy1 = busy;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1 cyc++;
            start = (mid_start != 0 && cyc == mid_start);
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [23:0] ent;
        logic [31:0] exp;
    } vec_t;

    vec_t V[4];
    int   c, cref, base, s0, p0, a0, g0, n0;
    logic b1;

    initial begin
        V[0] = '{24'h300882, 32'h78300882};
        V[1] = '{24'h1234A5, 32'h781234A5};
        V[2] = '{24'h00FF00, 32'h7800FF00};
        V[3] = '{24'hFFFE01, 32'h78FFFE01};
        for (int i = 0; i < 256; i++) tbl[i] = 24'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(taddr), 32'd0);
        rst_n = 1'b1;

        // single-entry writes
        for (int i = 0; i < 4; i++) begin
            tbl[0] = V[i].ent;
            base = bq.size(); s0 = nstart; p0 = nstop;
            run(8'd1, 0, c, b1);
            chk($sformatf("v%0d_busy", i), 32'(b1), 32'd1);
            chk($sformatf("v%0d_nbytes", i), 32'(bq.size() - base), 32'd4);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_byte%0d", i, k), 32'(gb(base + k)), 32'(V[i].exp[31-8*k -: 8]));
            chk($sformatf("v%0d_starts", i), 32'(nstart - s0), 32'd1);
            chk($sformatf("v%0d_stops", i), 32'(nstop - p0), 32'd1);
            chk($sformatf("v%0d_done_lat(%0d)", i, c), 32'(c >= 306 && c <= 340), 32'd1);
        end

        // three entries: framing, table walk, idle gap
        tbl[0] = 24'h300882; tbl[1] = 24'h310303; tbl[2] = 24'h3017FF;
        base = bq.size(); s0 = nstart; p0 = nstop; a0 = alog.size(); g0 = gap_bad;
        run(8'd3, 0, c, b1);
        chk("len3_starts", 32'(nstart - s0), 32'd3);
        chk("len3_stops", 32'(nstop - p0), 32'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("len3_addr%0d", k), (a0 + k < alog.size()) ? 32'(alog[a0+k]) : 32'hFFFF, 32'(k));
        chk("len3_gap", 32'(gap_bad - g0), 32'd0);
        chk("len3_nbytes", 32'(bq.size() - base), 32'd12);
        chk("len3_byte9", 32'(gb(base + 9)), 32'h30);
        chk("len3_byte11", 32'(gb(base + 11)), 32'hFF);

        // empty table
        n0 = nchg;
        run(8'd0, 0, c, b1);
        chk("len0_done_fast", 32'(c <= 2), 32'd1);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_no_bus", 32'(nchg - n0), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);

        // restart while busy must be ignored
        run(8'd2, 0, cref, b1);
        s0 = nstart; base = bq.size();
        run(8'd2, 150, c, b1);
        chk("mid_start_cycles", 32'(c), 32'(cref));
        chk("mid_start_starts", 32'(nstart - s0), 32'd2);
        chk("mid_start_nbytes", 32'(bq.size() - base), 32'd8);

        // async reset during byte 2
        tbl[0] = 24'h300882;
        base = bq.size();
        @(posedge clk); #1 len = 8'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int w = 0; w < 1000 && bq.size() < base + 1; w++) @(posedge clk);
        chk("rstmid_byte1_seen", 32'(bq.size() >= base + 1), 32'd1);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid_scl", 32'(scl), 32'd1);
        chk("rstmid_sda_oe", 32'(sda_oe), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        base = bq.size(); s0 = nstart;
        run(8'd1, 0, c, b1);
        chk("rstmid_rerun_starts", 32'(nstart - s0), 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rstmid_rerun_byte%0d", k), 32'(gb(base + k)), 32'(V[0].exp[31-8*k -: 8]));

        // 16'hFFFF entry between two writes
        tbl[0] = 24'h300882; tbl[1] = 24'hFFFF02; tbl[2] = 24'h123456;
        base = bq.size(); s0 = nstart;
        run(8'd3, 0, c, b1);
`ifdef CAM_CFG_DELAY_EN
        chk("dly_starts", 32'(nstart - s0), 32'd2);
        chk("dly_nbytes", 32'(bq.size() - base), 32'd8);
        chk("dly_byte4", 32'(gb(base + 4)), 32'h78);
        chk("dly_byte5", 32'(gb(base + 5)), 32'h12);
        chk("dly_byte7", 32'(gb(base + 7)), 32'h56);
        chk($sformatf("dly_gap(%0d)", last_gap), 32'(last_gap >= 1600 && last_gap <= 1700), 32'd1);
`else
        chk("ffff_starts", 32'(nstart - s0), 32'd3);
        chk("ffff_nbytes", 32'(bq.size() - base), 32'd12);
        chk("ffff_byte4", 32'(gb(base + 4)), 32'h78);
        chk("ffff_byte5", 32'(gb(base + 5)), 32'hFF);
        chk("ffff_byte6", 32'(gb(base + 6)), 32'hFF);
        chk("ffff_byte7", 32'(gb(base + 7)), 32'h02);
        chk("ffff_byte11", 32'(gb(base + 11)), 32'h56);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
